// File: rtl/disp_source_sched_if.sv
// Signal bundle between the display scheduler and its environment (RTC/alarm inputs,
// segment-decoder outputs and the LCD refresh handshake).
interface disp_source_sched_if;
    logic       tick_1hz;
    logic [5:0] time_hh;
    logic [5:0] time_mm;
    logic [5:0] time_ss;
    logic [5:0] alarm_hh;
    logic [5:0] alarm_mm;
    logic       alarm_set_active;
    logic       alarm_ringing;
    logic       view_req;
    logic [3:0] disp_d0;
    logic [3:0] disp_d1;
    logic [3:0] disp_d2;
    logic [3:0] disp_d3;
    logic [3:0] disp_d4;
    logic [3:0] disp_d5;
    logic [5:0] disp_blank;
    logic [1:0] src_sel;
    logic       pm;
    logic       lcd_req;
    logic       lcd_ack;
    logic [3:0] lcd_hr1;
    logic [3:0] lcd_hr0;
    logic [3:0] lcd_min1;
    logic [3:0] lcd_min0;

    // Scheduler side
    modport master (
        input  tick_1hz, time_hh, time_mm, time_ss, alarm_hh, alarm_mm,
               alarm_set_active, alarm_ringing, view_req, lcd_ack,
        output disp_d0, disp_d1, disp_d2, disp_d3, disp_d4, disp_d5,
               disp_blank, src_sel, pm, lcd_req,
               lcd_hr1, lcd_hr0, lcd_min1, lcd_min0
    );

    // Environment side (clock/alarm sources, display and LCD sinks)
    modport slave (
        output tick_1hz, time_hh, time_mm, time_ss, alarm_hh, alarm_mm,
               alarm_set_active, alarm_ringing, view_req, lcd_ack,
        input  disp_d0, disp_d1, disp_d2, disp_d3, disp_d4, disp_d5,
               disp_blank, src_sel, pm, lcd_req,
               lcd_hr1, lcd_hr0, lcd_min1, lcd_min0
    );
endinterface

// File: rtl/disp_source_sched.sv
// Chooses what the six-digit bank and the LCD show (time, alarm edit, alarm peek, ringing).
// Define DISP_SCHED_12H_EN for a 12-hour display with PM indicator; default is 24-hour.
module disp_source_sched #(
    parameter int PEEK_SECONDS = 3
) (
    input  logic                clk_50MHz,
    input  logic                reset,
    disp_source_sched_if.master bus
);
    typedef enum logic [1:0] {
        ST_TIME      = 2'd0,
        ST_ALARM_SET = 2'd1,
        ST_PEEK      = 2'd2,
        ST_RING      = 2'd3
    } state_t;

    localparam logic [3:0] PEEK_LOAD = 4'(PEEK_SECONDS);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  timer;
    logic [3:0]  timer_nxt;
    logic        phase;
    logic        phase_nxt;
    logic        show_time;
    logic [5:0]  src_h;
    logic [5:0]  src_m;
    logic [5:0]  src_s;
    logic [5:0]  shown_h;
    logic [5:0]  blank_nxt;
    logic        pm_nxt;
    logic [15:0] shown_hm;
    logic [15:0] snap;

    function automatic logic [3:0] bcd_tens(input logic [5:0] v);
        return 4'(v / 6'd10);
    endfunction

    function automatic logic [3:0] bcd_units(input logic [5:0] v);
        return 4'(v % 6'd10);
    endfunction

    function automatic logic [5:0] map_hour(input logic [5:0] h);
`ifdef DISP_SCHED_12H_EN
        if (h == 6'd0)
            return 6'd12;
        else if ((h >= 6'd13) && (h <= 6'd23))
            return h - 6'd12;
        else
            return h;
`else
        return h;
`endif
    endfunction

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            state <= ST_TIME;
            timer <= 4'd0;
            phase <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            phase <= phase_nxt;
        end
    end

    // Priority arbitration; a peek only survives while nothing higher is active.
    always_comb begin
        state_nxt = ST_TIME;
        timer_nxt = 4'd0;
        phase_nxt = phase;
        if (bus.alarm_ringing) begin
            state_nxt = ST_RING;
        end else if (bus.alarm_set_active) begin
            state_nxt = ST_ALARM_SET;
        end else if (state == ST_PEEK) begin
            if (bus.view_req) begin
                state_nxt = ST_PEEK;
                timer_nxt = PEEK_LOAD;
            end else if (!(bus.tick_1hz && (timer <= 4'd1))) begin
                state_nxt = ST_PEEK;
                timer_nxt = bus.tick_1hz ? timer - 4'd1 : timer;
            end
        end else if ((state == ST_TIME) && bus.view_req) begin
            state_nxt = ST_PEEK;
            timer_nxt = PEEK_LOAD;
        end
        if (state_nxt != state)
            phase_nxt = 1'b0;
        else if (bus.tick_1hz)
            phase_nxt = ~phase;
    end

    always_comb begin
        show_time = (state_nxt == ST_TIME) || (state_nxt == ST_RING);
        src_h     = show_time ? bus.time_hh : bus.alarm_hh;
        src_m     = show_time ? bus.time_mm : bus.alarm_mm;
        src_s     = show_time ? bus.time_ss : 6'd0;
        shown_h   = map_hour(src_h);
        blank_nxt = 6'b000000;
        case (state_nxt)
            ST_PEEK:      blank_nxt = 6'b000011;
            ST_ALARM_SET: blank_nxt = phase_nxt ? 6'b111111 : 6'b000011;
            ST_RING:      blank_nxt = phase_nxt ? 6'b111111 : 6'b000000;
            default:      blank_nxt = 6'b000000;
        endcase
    end

`ifdef DISP_SCHED_12H_EN
    assign pm_nxt = (src_h >= 6'd12) && (src_h <= 6'd23);
`else
    assign pm_nxt = 1'b0;
`endif

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            bus.disp_d0    <= 4'd0;
            bus.disp_d1    <= 4'd0;
            bus.disp_d2    <= 4'd0;
            bus.disp_d3    <= 4'd0;
            bus.disp_d4    <= 4'd0;
            bus.disp_d5    <= 4'd0;
            bus.disp_blank <= 6'b000000;
            bus.src_sel    <= 2'd0;
            bus.pm         <= 1'b0;
        end else begin
            bus.disp_d0    <= bcd_units(src_s);
            bus.disp_d1    <= bcd_tens(src_s);
            bus.disp_d2    <= bcd_units(src_m);
            bus.disp_d3    <= bcd_tens(src_m);
            bus.disp_d4    <= bcd_units(shown_h);
            bus.disp_d5    <= bcd_tens(shown_h);
            bus.disp_blank <= blank_nxt;
            bus.src_sel    <= state_nxt;
            bus.pm         <= pm_nxt;
        end
    end

    assign shown_hm = {bus.disp_d5, bus.disp_d4, bus.disp_d3, bus.disp_d2};

    // Changes during a pending request are dropped; the compare reruns once lcd_req is low.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            bus.lcd_req  <= 1'b0;
            bus.lcd_hr1  <= 4'd0;
            bus.lcd_hr0  <= 4'd0;
            bus.lcd_min1 <= 4'd0;
            bus.lcd_min0 <= 4'd0;
            snap         <= 16'd0;
        end else if (bus.lcd_req) begin
            if (bus.lcd_ack) begin
                snap        <= {bus.lcd_hr1, bus.lcd_hr0, bus.lcd_min1, bus.lcd_min0};
                bus.lcd_req <= 1'b0;
            end
        end else if (shown_hm != snap) begin
            bus.lcd_req <= 1'b1;
            {bus.lcd_hr1, bus.lcd_hr0, bus.lcd_min1, bus.lcd_min0} <= shown_hm;
        end
    end
endmodule

// File: tb/tb_disp_source_sched.sv
// Self-checking bench for disp_source_sched: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the display/LCD rules.
module tb_disp_source_sched;
    localparam int PEEK_SECONDS = 3;
    localparam int M_TIME = 0, M_ASET = 1, M_PEEK = 2, M_RING = 3;

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    disp_source_sched_if bus();

    disp_source_sched #(.PEEK_SECONDS(PEEK_SECONDS)) dut (
        .clk_50MHz (clk),
        .reset     (reset),
        .bus       (bus.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int m_mode, m_left, m_phase;
    int e_d[6];
    int e_blank, e_src, e_pm, e_req;
    int e_lcd[4];
    int e_snap[4];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

`ifdef DISP_SCHED_12H_EN
    function automatic int hour12(input int h);
        if (h == 0) return 12;
        if (h >= 13 && h <= 23) return h - 12;
        return h;
    endfunction
`endif

    task automatic model_reset();
        m_mode = M_TIME; m_left = 0; m_phase = 0;
        e_blank = 0; e_src = 0; e_pm = 0; e_req = 0;
        for (int k = 0; k < 6; k++) e_d[k] = 0;
        for (int k = 0; k < 4; k++) begin e_lcd[k] = 0; e_snap[k] = 0; end
    endtask

    // Advances the model across one clock edge using the inputs currently applied.
    task automatic model_edge();
        int nm, nl, np, hv, mv, sv;
        bit differs;
        if (reset) begin
            model_reset();
            return;
        end
        // LCD side looks at the digits that were on display before this edge
        if (e_req != 0) begin
            if (bus.lcd_ack) begin
                for (int k = 0; k < 4; k++) e_snap[k] = e_lcd[k];
                e_req = 0;
            end
        end else begin
            differs = 0;
            for (int k = 0; k < 4; k++) if (e_d[k + 2] != e_snap[k]) differs = 1;
            if (differs) begin
                e_req = 1;
                for (int k = 0; k < 4; k++) e_lcd[k] = e_d[k + 2];
            end
        end
        nl = 0;
        if (bus.alarm_ringing) nm = M_RING;
        else if (bus.alarm_set_active) nm = M_ASET;
        else if (m_mode == M_PEEK && bus.view_req) begin nm = M_PEEK; nl = PEEK_SECONDS; end
        else if (m_mode == M_PEEK) begin
            nl = m_left - (bus.tick_1hz ? 1 : 0);
            if (nl > 0) nm = M_PEEK;
            else begin nm = M_TIME; nl = 0; end
        end
        else if (m_mode == M_TIME && bus.view_req) begin nm = M_PEEK; nl = PEEK_SECONDS; end
        else nm = M_TIME;
        np = (nm != m_mode) ? 0 : (bus.tick_1hz ? 1 - m_phase : m_phase);
        m_mode = nm; m_left = nl; m_phase = np;

        if (nm == M_TIME || nm == M_RING) begin
            hv = int'(bus.time_hh); mv = int'(bus.time_mm); sv = int'(bus.time_ss);
        end else begin
            hv = int'(bus.alarm_hh); mv = int'(bus.alarm_mm); sv = 0;
        end
        e_pm = 0;
`ifdef DISP_SCHED_12H_EN
        e_pm = (hv >= 12 && hv <= 23) ? 1 : 0;
        hv = hour12(hv);
`endif
        e_d[5] = hv / 10; e_d[4] = hv % 10;
        e_d[3] = mv / 10; e_d[2] = mv % 10;
        e_d[1] = sv / 10; e_d[0] = sv % 10;
        case (nm)
            M_PEEK:  e_blank = 3;
            M_ASET:  e_blank = np ? 63 : 3;
            M_RING:  e_blank = np ? 63 : 0;
            default: e_blank = 0;
        endcase
        e_src = nm;
    endtask

    task automatic compare_all();
        check_val("d0", 32'(bus.disp_d0), e_d[0]);
        check_val("d1", 32'(bus.disp_d1), e_d[1]);
        check_val("d2", 32'(bus.disp_d2), e_d[2]);
        check_val("d3", 32'(bus.disp_d3), e_d[3]);
        check_val("d4", 32'(bus.disp_d4), e_d[4]);
        check_val("d5", 32'(bus.disp_d5), e_d[5]);
        check_val("blank", 32'(bus.disp_blank), e_blank);
        check_val("src_sel", 32'(bus.src_sel), e_src);
        check_val("pm", 32'(bus.pm), e_pm);
        check_val("lcd_req", 32'(bus.lcd_req), e_req);
        check_val("lcd_hr1", 32'(bus.lcd_hr1), e_lcd[3]);
        check_val("lcd_hr0", 32'(bus.lcd_hr0), e_lcd[2]);
        check_val("lcd_min1", 32'(bus.lcd_min1), e_lcd[1]);
        check_val("lcd_min0", 32'(bus.lcd_min0), e_lcd[0]);
    endtask

    // One clock: model, edge, sample 1 time unit later, then drop the single-cycle pulses.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
        bus.tick_1hz = 1'b0;
        bus.view_req = 1'b0;
        bus.lcd_ack  = 1'b0;
    endtask

    task automatic tick_step();
        bus.tick_1hz = 1'b1;
        step();
        step();
    endtask

    task automatic drain_lcd();
        for (int i = 0; i < 12; i++) begin
            bus.lcd_ack = bus.lcd_req;
            step();
        end
    endtask

    task automatic set_time(input int h, input int m, input int s);
        bus.time_hh = 6'(h); bus.time_mm = 6'(m); bus.time_ss = 6'(s);
    endtask

    initial begin
        reset = 1'b1;
        bus.tick_1hz = 0; bus.view_req = 0; bus.lcd_ack = 0;
        bus.alarm_set_active = 0; bus.alarm_ringing = 0;
        set_time(0, 0, 0);
        bus.alarm_hh = 6'd0; bus.alarm_mm = 6'd0;
        model_reset();
        step();
        step();
        check_val("rst_src", 32'(bus.src_sel), 0);
        check_val("rst_blank", 32'(bus.disp_blank), 0);
        check_val("rst_req", 32'(bus.lcd_req), 0);
        reset = 1'b0;

        // Time 13:45:07 and first LCD request
        set_time(13, 45, 7);
        step();
        step();
`ifdef DISP_SCHED_12H_EN
        check_val("t_d5", 32'(bus.disp_d5), 0);
        check_val("t_d4", 32'(bus.disp_d4), 1);
        check_val("t_pm", 32'(bus.pm), 1);
`else
        check_val("t_d5", 32'(bus.disp_d5), 1);
        check_val("t_d4", 32'(bus.disp_d4), 3);
        check_val("t_lcd_hr0", 32'(bus.lcd_hr0), 3);
`endif
        check_val("t_d3", 32'(bus.disp_d3), 4);
        check_val("t_d2", 32'(bus.disp_d2), 5);
        check_val("t_d1", 32'(bus.disp_d1), 0);
        check_val("t_d0", 32'(bus.disp_d0), 7);
        check_val("t_req", 32'(bus.lcd_req), 1);
        check_val("t_lcd_min0", 32'(bus.lcd_min0), 5);
        bus.lcd_ack = 1'b1;
        step();
        check_val("t_req_drop", 32'(bus.lcd_req), 0);
        step(); step(); step();
        check_val("t_req_idle", 32'(bus.lcd_req), 0);

        // Alarm peek and its extension
        bus.alarm_hh = 6'd6; bus.alarm_mm = 6'd30;
        bus.view_req = 1'b1;
        step();
        check_val("pk_src", 32'(bus.src_sel), 2);
        check_val("pk_d5", 32'(bus.disp_d5), 0);
        check_val("pk_d4", 32'(bus.disp_d4), 6);
        check_val("pk_d3", 32'(bus.disp_d3), 3);
        check_val("pk_d0", 32'(bus.disp_d0), 0);
        check_val("pk_blank", 32'(bus.disp_blank), 3);
        tick_step(); tick_step();
        check_val("pk_src_t2", 32'(bus.src_sel), 2);
        tick_step();
        check_val("pk_end", 32'(bus.src_sel), 0);
        bus.view_req = 1'b1;
        step();
        tick_step(); tick_step();
        bus.view_req = 1'b1;
        step();
        tick_step(); tick_step();
        check_val("pk_ext", 32'(bus.src_sel), 2);
        tick_step();
        check_val("pk_ext_end", 32'(bus.src_sel), 0);

        // Alarm edit blink, then ringing on top
        bus.alarm_set_active = 1'b1;
        step();
        check_val("as_src", 32'(bus.src_sel), 1);
        check_val("as_blank0", 32'(bus.disp_blank), 3);
        tick_step();
        check_val("as_blank1", 32'(bus.disp_blank), 63);
        tick_step();
        check_val("as_blank2", 32'(bus.disp_blank), 3);
        bus.alarm_ringing = 1'b1;
        step();
        check_val("rg_src", 32'(bus.src_sel), 3);
        check_val("rg_blank0", 32'(bus.disp_blank), 0);
        tick_step();
        check_val("rg_blank1", 32'(bus.disp_blank), 63);
        tick_step();
        check_val("rg_blank2", 32'(bus.disp_blank), 0);
        bus.alarm_ringing = 1'b0; bus.alarm_set_active = 1'b0;

        // Minute change while a request for 12:00 is pending
        set_time(11, 59, 0);
        drain_lcd();
        set_time(12, 0, 0);
        step();
        step();
        check_val("pd_req", 32'(bus.lcd_req), 1);
        set_time(12, 1, 0);
        step(); step(); step();
        check_val("pd_hold_req", 32'(bus.lcd_req), 1);
        check_val("pd_hold_hr1", 32'(bus.lcd_hr1), 1);
        check_val("pd_hold_hr0", 32'(bus.lcd_hr0), 2);
        check_val("pd_hold_min0", 32'(bus.lcd_min0), 0);
        bus.lcd_ack = 1'b1;
        step();
        check_val("pd_gap", 32'(bus.lcd_req), 0);
        step();
        check_val("pd_rereq", 32'(bus.lcd_req), 1);
        check_val("pd_new_min0", 32'(bus.lcd_min0), 1);

        // Reset during a peek with a request pending
        drain_lcd();
        bus.view_req = 1'b1;
        step();
        step();
        check_val("mr_pre_src", 32'(bus.src_sel), 2);
        check_val("mr_pre_req", 32'(bus.lcd_req), 1);
        reset = 1'b1;
        step();
        check_val("mr_src", 32'(bus.src_sel), 0);
        check_val("mr_req", 32'(bus.lcd_req), 0);
        reset = 1'b0;
        tick_step();
        check_val("mr_no_resume", 32'(bus.src_sel), 0);

        // 12/24-hour mapping of edge hours
        drain_lcd();
        set_time(0, 15, 0);
        step();
`ifdef DISP_SCHED_12H_EN
        check_val("h_00_d5", 32'(bus.disp_d5), 1);
        check_val("h_00_d4", 32'(bus.disp_d4), 2);
`else
        check_val("h_00_d5", 32'(bus.disp_d5), 0);
        check_val("h_00_d4", 32'(bus.disp_d4), 0);
`endif
        check_val("h_00_pm", 32'(bus.pm), 0);
        set_time(23, 59, 0);
        step();
`ifdef DISP_SCHED_12H_EN
        check_val("h_23_d5", 32'(bus.disp_d5), 1);
        check_val("h_23_d4", 32'(bus.disp_d4), 1);
        check_val("h_23_pm", 32'(bus.pm), 1);
`else
        check_val("h_23_d5", 32'(bus.disp_d5), 2);
        check_val("h_23_d4", 32'(bus.disp_d4), 3);
        check_val("h_23_pm", 32'(bus.pm), 0);
`endif
        check_val("h_23_d3", 32'(bus.disp_d3), 5);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 499) == 0);
            bus.tick_1hz = ($urandom_range(0, 5) == 0);
            bus.view_req = ($urandom_range(0, 9) == 0);
            if (bus.lcd_req) bus.lcd_ack = ($urandom_range(0, 2) == 0);
            else             bus.lcd_ack = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 59) == 0) bus.alarm_set_active = ~bus.alarm_set_active;
            if ($urandom_range(0, 79) == 0) bus.alarm_ringing = ~bus.alarm_ringing;
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 3) == 0)
                    set_time($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
                else
                    set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            end
            if ($urandom_range(0, 19) == 0) begin
                bus.alarm_hh = 6'($urandom_range(0, 63));
                bus.alarm_mm = 6'($urandom_range(0, 59));
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/disp_source_sched.md
# disp_source_sched

Sequencing controller that decides what the six-digit seven-segment bank and the LT24 LCD show at any instant: live time, alarm setting, a timed alarm "peek", or a flashing ringing display. It sits between the real-time clock / alarm blocks and the segment decoder and LCD controller. It performs binary-to-BCD conversion, blink scheduling and priority arbitration, and runs a request/acknowledge handshake so the LCD controller is only refreshed when the shown content changes.

## Interface
Parameters:
- PEEK_SECONDS, 3, seconds an alarm peek stays on screen (legal 1..15).

Ports:
- clk_50MHz  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- tick_1hz  in  1  single-cycle strobe, once per second, synchronous to clk_50MHz.
- time_hh / time_mm / time_ss  in  6 each  binary current time.
- alarm_hh / alarm_mm  in  6 each  binary alarm setting.
- alarm_set_active  in  1  level; user is editing the alarm.
- alarm_ringing  in  1  level; alarm is firing.
- view_req  in  1  single-cycle debounced key pulse requesting an alarm peek.
- disp_d0..disp_d5  out  4 each  BCD digits (d0 = seconds units ... d5 = hours tens).
- disp_blank  out  6  per-digit blank, 1 = digit off.
- src_sel  out  2  0 = TIME, 1 = ALARM_SET, 2 = PEEK, 3 = RING.
- pm  out  1  PM indicator (12-hour build only).
- lcd_req  out  1  LCD refresh request.
- lcd_ack  in  1  single-cycle acknowledge from LCD controller.
- lcd_hr1 / lcd_hr0 / lcd_min1 / lcd_min0  out  4 each  snapshot digits for the LCD, stable while lcd_req = 1.

## Operation
- State machine: TIME, ALARM_SET, PEEK, RING. Priority is evaluated every cycle: alarm_ringing → RING; else alarm_set_active → ALARM_SET; else PEEK if in PEEK and the timer is not expired; else TIME.
- PEEK is entered only from TIME, on view_req. The 4-bit timer loads PEEK_SECONDS. Each tick_1hz decrements it. A tick while the timer is 1 returns to TIME. view_req while in PEEK reloads the timer. view_req in any other state is ignored.
- Leaving PEEK because of a higher-priority state clears the timer; PEEK does not resume afterwards.
- Blink phase bit: toggles on every tick_1hz; cleared on every state change.
- Digit sources:
  - TIME and RING take hours/minutes/seconds from time_*.
  - ALARM_SET and PEEK take hours/minutes from alarm_*; d1/d0 are driven 0 and always blanked.
- Conversion: tens = value/10, units = value%10, on the 6-bit value. Out-of-range inputs are shown as computed (e.g. 63 → 6,3) with no saturation.
- Blanking:
  - TIME: none.
  - PEEK: d1/d0 only.
  - ALARM_SET: d1/d0, plus d5..d2 when phase = 1.
  - RING: all six digits when phase = 1.
- LCD handshake:
  - A snapshot register holds the hours/minutes last accepted by the LCD.
  - When lcd_req = 0 and the registered hour/minute digits differ from the snapshot, assert lcd_req and drive lcd_* with the current digits.
  - lcd_req holds, with lcd_* frozen, until lcd_ack. On lcd_ack, the snapshot is set to lcd_*, and lcd_req deasserts on the next edge.
  - lcd_ack while lcd_req = 0 is ignored.
  - Changes during a pending request are not queued. After lcd_req drops, the newest digits are compared again, so at most one stale frame is shown.

## Timing
- Reset values:
  - State TIME, timer 0, phase 0.
  - All disp_d* = 0, disp_blank = 6'b000000, src_sel = 0, pm = 0.
  - lcd_req = 0, lcd_* = 0, snapshot = 0.
  - An asserted reset mid-handshake drops lcd_req in the same edge.
- All outputs are registered: 1-cycle latency from an input change or state decision to disp_*, src_sel and pm.
- lcd_req rises at the earliest 1 cycle after the display registers change. It falls 1 cycle after lcd_ack. It is low for at least 1 cycle between requests.
- Simultaneous tick_1hz and view_req in PEEK: the reload wins and the timer becomes PEEK_SECONDS.
- Simultaneous alarm_ringing rise and view_req in TIME: the next state is RING.

## Configuration
- DISP_SCHED_12H_EN defined: displayed hours are mapped before BCD conversion (0 → 12; 13..23 → value − 12; 1..12 unchanged). pm = 1 for source hours 12..23. The mapping applies to both time and alarm sources, and the LCD digits use the mapped value.
- Not defined: 24-hour display, and pm is tied to 0.

## Test plan
- Reset, then time 13:45:07 → after 2 cycles digits 1,3,4,5,0,7, blank 000000, src_sel 0, lcd_req = 1 with lcd 1,3,4,5; ack → lcd_req = 0 next cycle, and it stays 0 while the time is unchanged.
- TIME, view_req, PEEK_SECONDS = 3, alarm 06:30 → src_sel 2, digits 0,6,3,0, blank 000011; after 3 ticks src_sel 0; a view_req after tick 2 extends the peek by 3 more ticks.
- alarm_set_active = 1 → src_sel 1, digits d5..d2 blank only on alarternate ticks (phase 1); alarm_ringing asserted concurrently → src_sel 3, all digits blink each tick.
- Minute changes 12:00 → 12:01 while lcd_req is pending for 12:00 → lcd_* remain 1,2,0,0 until ack; lcd_req is low for 1 cycle, then re-requests 1,2,0,1.
- Reset asserted mid-PEEK and mid-handshake → next cycle src_sel 0, timer 0, lcd_req 0.
- DISP_SCHED_12H_EN build: time 00:15 → 1,2,1,5, pm 0; time 23:59 → 1,1,5,9, pm 1.
